// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types for the execute-stage hazard scheduler.
// Holds the forward-select encoding, the control bundle and the mul/div FSM states.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    RD      = 2'd0,
    ALUOUTE = 2'd1,
    ALUOUTM = 2'd2,
    MEMDATA = 2'd3
  } forward_t;

  typedef struct packed {
    forward_t ac;
    forward_t bc;
  } supercontrol_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Operand source for one E-stage read port; the younger M result wins over W.
  function automatic forward_t fwd_sel(input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] dst_m,
                                       input logic             regwrite_m,
                                       input logic             memread_m,
                                       input logic [REG_W-1:0] dst_w,
                                       input logic             regwrite_w);
    forward_t sel;
    sel = RD;
    if (rs != '0) begin
      if (regwrite_m && (dst_m == rs)) begin
        sel = memread_m ? MEMDATA : ALUOUTE;
      end else if (regwrite_w && (dst_w == rs)) begin
        sel = ALUOUTM;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Tracks how long a multiply/divide keeps the execute stage occupied.
// Raises md_stall while the operation still needs E; completion waits out any data-memory stall.
module hazard_ctrl_md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mdstartE,
  input  logic mdisdivE,
  input  logic dwait,
  output logic md_stall
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] start_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A single-cycle unit (start count 0) never enters BUSY and never stalls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_stall  = 1'b0;
    start_cnt = mdisdivE ? DIV_CNT : MUL_CNT;
    unique case (state_q)
      IDLE: begin
        if (mdstartE && (start_cnt != '0)) begin
          state_d  = BUSY;
          cnt_d    = start_cnt;
          md_stall = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          md_stall = 1'b1;
        end else if (!dwait) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard scheduler: operand forwarding selects plus per-stage stall/flush
// controls for data-memory wait, mul/div occupancy, load-use and taken-branch redirect.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] dstE,
  input  logic             memreadE,
  input  logic [REG_W-1:0] dstM,
  input  logic             regwriteM,
  input  logic             memreadM,
  input  logic [REG_W-1:0] dstW,
  input  logic             regwriteW,
  input  logic             mdstartE,
  input  logic             mdisdivE,
  input  logic             dwait,
  input  logic             iwait,
  input  logic             branchE,
  output supercontrol_t    sctlE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             ikill
);

  logic md_stall;
  logic load_use;
  logic branch_go;
  logic ikill_q, ikill_d;

  hazard_ctrl_md_sequencer #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_md_sequencer (
    .clk     (clk),
    .reset   (reset),
    .mdstartE(mdstartE),
    .mdisdivE(mdisdivE),
    .dwait   (dwait),
    .md_stall(md_stall)
  );

  assign load_use = memreadE && (dstE != '0) && ((dstE == rs1D) || (dstE == rs2D));

  always_ff @(posedge clk) begin
    if (reset) begin
      ikill_q <= 1'b0;
    end else begin
      ikill_q <= ikill_d;
    end
  end

  // Hazards resolve in priority order: dwait, mul/div, load-use, branch, then a lone fetch wait.
  always_comb begin
    sctlE     = '{ac: RD, bc: RD};
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    branch_go = 1'b0;
    if (!reset) begin
      sctlE.ac = fwd_sel(rs1E, dstM, regwriteM, memreadM, dstW, regwriteW);
      sctlE.bc = fwd_sel(rs2E, dstM, regwriteM, memreadM, dstW, regwriteW);
      if (dwait) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (md_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (load_use) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (branchE) begin
        flushD    = 1'b1;
        flushE    = 1'b1;
        branch_go = 1'b1;
      end else if (iwait) begin
        stallF = 1'b1;
        flushD = 1'b1;
      end
    end
  end

  // A redirect during an outstanding fetch marks that fetch for discard until it returns.
  always_comb begin
    ikill_d = ikill_q;
    if (branch_go && iwait) begin
      ikill_d = 1'b1;
    end else if (!iwait) begin
      ikill_d = 1'b0;
    end
  end

  assign ikill = ikill_q && !reset;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle hazard vectors plus
// hand-written multi-cycle sequences for mul/div, fetch kill and mid-operation reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic          clk;
  logic          reset;
  logic [4:0]    rs1E, rs2E, rs1D, rs2D, dstE, dstM, dstW;
  logic          memreadE, regwriteM, memreadM, regwriteW;
  logic          mdstartE, mdisdivE, dwait, iwait, branchE;
  supercontrol_t sctlE;
  logic          stallF, stallD, stallE, stallM, flushD, flushE, flushM, ikill;

  int checks = 0;
  int errors = 0;

  // ctl bit order: {stallF, stallD, stallE, stallM, flushD, flushE, flushM}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_MD   = 7'b1110001;
  localparam logic [6:0] C_DW   = 7'b1111000;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_IW   = 7'b1000100;

  hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16)) dut (
    .clk(clk), .reset(reset),
    .rs1E(rs1E), .rs2E(rs2E), .rs1D(rs1D), .rs2D(rs2D), .dstE(dstE), .memreadE(memreadE),
    .dstM(dstM), .regwriteM(regwriteM), .memreadM(memreadM),
    .dstW(dstW), .regwriteW(regwriteW),
    .mdstartE(mdstartE), .mdisdivE(mdisdivE), .dwait(dwait), .iwait(iwait), .branchE(branchE),
    .sctlE(sctlE), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .ikill(ikill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1E, rs2E, rs1D, rs2D, dstE;
    logic       memreadE;
    logic [4:0] dstM;
    logic       regwriteM, memreadM;
    logic [4:0] dstW;
    logic       regwriteW, dwait, iwait, branchE;
    forward_t   ac, bc;
    logic [6:0] ctl;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] a1E, a2E, a1D, a2D, dE, input logic mrE,
                              input logic [4:0] dM, input logic rwM, mrM,
                              input logic [4:0] dW, input logic rwW, dw, iw, br,
                              input forward_t ac, bc, input logic [6:0] ctl);
    vec_t v;
    v.rs1E = a1E; v.rs2E = a2E; v.rs1D = a1D; v.rs2D = a2D; v.dstE = dE; v.memreadE = mrE;
    v.dstM = dM; v.regwriteM = rwM; v.memreadM = mrM; v.dstW = dW; v.regwriteW = rwW;
    v.dwait = dw; v.iwait = iw; v.branchE = br; v.ac = ac; v.bc = bc; v.ctl = ctl;
    return v;
  endfunction

  function automatic logic [13:0] ex(input forward_t ac, bc, input logic [6:0] ctl, input logic ik);
    return {ac, bc, ctl, ik};
  endfunction

  task automatic clear_in();
    rs1E = '0; rs2E = '0; rs1D = '0; rs2D = '0; dstE = '0; memreadE = 1'b0;
    dstM = '0; regwriteM = 1'b0; memreadM = 1'b0; dstW = '0; regwriteW = 1'b0;
    mdstartE = 1'b0; mdisdivE = 1'b0; dwait = 1'b0; iwait = 1'b0; branchE = 1'b0;
  endtask

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] got;
    got = {sctlE.ac, sctlE.bc, stallF, stallD, stallE, stallM, flushD, flushE, flushM, ikill};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  vec_t vecs[$];

  initial begin
    clear_in();
    reset = 1'b1;
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  RD, RD, C_NONE));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0,  1, 1, 0,  0, 0,  0, 0, 0,  ALUOUTE, RD, C_NONE));
    vecs.push_back(mk(3, 1, 0, 0, 0, 0,  0, 0, 0,  1, 1,  0, 0, 0,  RD, ALUOUTM, C_NONE));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 0,  0, 1,  0, 0, 0,  RD, RD, C_NONE));
    vecs.push_back(mk(5, 5, 0, 0, 0, 0,  5, 1, 1,  0, 0,  0, 0, 0,  MEMDATA, MEMDATA, C_NONE));
    vecs.push_back(mk(3, 4, 0, 0, 0, 0,  3, 1, 0,  3, 1,  0, 0, 0,  ALUOUTE, RD, C_NONE));
    vecs.push_back(mk(7, 7, 0, 0, 0, 0,  7, 0, 0,  7, 1,  0, 0, 0,  ALUOUTM, ALUOUTM, C_NONE));
    vecs.push_back(mk(6, 6, 0, 0, 0, 0,  6, 1, 1,  6, 1,  0, 0, 0,  MEMDATA, MEMDATA, C_NONE));
    vecs.push_back(mk(0, 0, 9, 5, 5, 1,  0, 0, 0,  0, 0,  0, 0, 0,  RD, RD, C_LU));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0,  0, 0, 0,  RD, RD, C_NONE));
    vecs.push_back(mk(0, 0, 5, 0, 5, 0,  0, 0, 0,  0, 0,  0, 0, 0,  RD, RD, C_NONE));
    vecs.push_back(mk(0, 0, 5, 0, 5, 1,  0, 0, 0,  0, 0,  0, 0, 1,  RD, RD, C_LU));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 1,  RD, RD, C_BR));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0,  RD, RD, C_IW));
    vecs.push_back(mk(0, 0, 5, 0, 5, 1,  0, 0, 0,  0, 0,  1, 0, 1,  RD, RD, C_DW));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0,  2, 1, 0,  0, 0,  1, 0, 0,  ALUOUTE, RD, C_DW));

    // Reset holds every output at its idle value whatever the inputs say.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rs1E = 5'd1; dstM = 5'd1; regwriteM = 1'b1; dwait = 1'b1; branchE = 1'b1;
    memreadE = 1'b1; dstE = 5'd4; rs1D = 5'd4; mdstartE = 1'b1;
    #2 chk("reset_state", ex(RD, RD, C_NONE, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    clear_in();
    #2 chk("post_reset_idle", ex(RD, RD, C_NONE, 1'b0));

    foreach (vecs[i]) begin
      @(negedge clk);
      clear_in();
      rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E; rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D;
      dstE = vecs[i].dstE; memreadE = vecs[i].memreadE;
      dstM = vecs[i].dstM; regwriteM = vecs[i].regwriteM; memreadM = vecs[i].memreadM;
      dstW = vecs[i].dstW; regwriteW = vecs[i].regwriteW;
      dwait = vecs[i].dwait; iwait = vecs[i].iwait; branchE = vecs[i].branchE;
      #2 chk($sformatf("vec%0d", i), ex(vecs[i].ac, vecs[i].bc, vecs[i].ctl, 1'b0));
    end

    // ld x5; add x6,x5: one bubble, then the load data is forwarded from M.
    @(negedge clk);
    clear_in(); memreadE = 1'b1; dstE = 5'd5; rs1D = 5'd5;
    #2 chk("lu_stall", ex(RD, RD, C_LU, 1'b0));
    @(negedge clk);
    clear_in(); rs1E = 5'd5; dstM = 5'd5; regwriteM = 1'b1; memreadM = 1'b1;
    #2 chk("lu_memdata", ex(MEMDATA, RD, C_NONE, 1'b0));

    // Multiply occupies E for three cycles and outranks a concurrent load-use.
    @(negedge clk);
    clear_in(); mdstartE = 1'b1;
    #2 chk("mul_c0", ex(RD, RD, C_MD, 1'b0));
    @(negedge clk);
    clear_in(); memreadE = 1'b1; dstE = 5'd5; rs1D = 5'd5;
    #2 chk("mul_c1_over_lu", ex(RD, RD, C_MD, 1'b0));
    @(negedge clk);
    clear_in();
    #2 chk("mul_c2", ex(RD, RD, C_MD, 1'b0));
    @(negedge clk);
    #2 chk("mul_c3_release", ex(RD, RD, C_NONE, 1'b0));

    // Divide with a five-cycle dwait starting at cnt==2; release waits for dwait to drop.
    @(negedge clk);
    clear_in(); mdstartE = 1'b1; mdisdivE = 1'b1;
    #2 chk("div_c0", ex(RD, RD, C_MD, 1'b0));
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      clear_in();
      dwait = (c >= 14 && c <= 18);
      #2 chk($sformatf("div_c%0d", c),
             ex(RD, RD, (c <= 13) ? C_MD : ((c <= 18) ? C_DW : C_NONE), 1'b0));
    end

    // Taken branch while a fetch is outstanding: ikill covers the cycle that fetch returns.
    @(negedge clk);
    clear_in(); branchE = 1'b1; iwait = 1'b1;
    #2 chk("br_iwait_t0", ex(RD, RD, C_BR, 1'b0));
    @(negedge clk);
    clear_in(); iwait = 1'b1;
    #2 chk("br_iwait_t1", ex(RD, RD, C_IW, 1'b1));
    @(negedge clk);
    #2 chk("br_iwait_t2", ex(RD, RD, C_IW, 1'b1));
    @(negedge clk);
    iwait = 1'b0;
    #2 chk("br_iwait_drop", ex(RD, RD, C_NONE, 1'b1));
    @(negedge clk);
    #2 chk("br_ikill_clear", ex(RD, RD, C_NONE, 1'b0));

    // Reset asserted mid-divide at cnt==7 returns the sequencer to idle.
    @(negedge clk);
    clear_in(); mdstartE = 1'b1; mdisdivE = 1'b1;
    #2 chk("rdiv_c0", ex(RD, RD, C_MD, 1'b0));
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      clear_in();
      #2 chk($sformatf("rdiv_c%0d", c), ex(RD, RD, C_MD, 1'b0));
    end
    @(negedge clk);
    clear_in(); reset = 1'b1; dwait = 1'b1; rs1E = 5'd1; dstM = 5'd1; regwriteM = 1'b1;
    #2 chk("rdiv_reset_cycle", ex(RD, RD, C_NONE, 1'b0));
    @(negedge clk);
    clear_in(); reset = 1'b0;
    #2 chk("rdiv_after_reset", ex(RD, RD, C_NONE, 1'b0));
    @(negedge clk);
    #2 chk("rdiv_after_reset2", ex(RD, RD, C_NONE, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
